// File: rtl/btn_pkg.sv
// Shared types and constants for the contact-bounce generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GLITCH = 2'd1,
        HOLD   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_MASK     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // One right-shift Galois step; the mask is applied when a 1 drops out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
    endfunction

endpackage

// File: rtl/btn_bounce_gen_lfsr16.sv
// 16-bit Galois LFSR that supplies the pseudo-random phase widths.
// Latency: q updates one cycle after each enabled edge.
// Backpressure: none; en simply freezes the sequence.
module lfsr16
    import btn_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] seed_eff;

    // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
    assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= seed_eff;
        end else if (en) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/btn_bounce_gen.sv
// Turns a clean commanded level into a bouncy button signal with glitch bursts.
// Latency: btn_out follows a detected level change one cycle after the sampling edge.
// Backpressure: level_in is ignored while busy; a pending change is taken on the first idle cycle.
module btn_bounce_gen
    import btn_pkg::*;
#(
    parameter int          BOUNCES    = 4,
    parameter int          W          = 3,
    parameter int          SETTLE_CYC = 16,
    parameter logic [15:0] SEED       = LFSR_SEED_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic btn_out,
    output logic busy
);

    localparam int            SW          = $clog2(SETTLE_CYC + 1);
    localparam logic [3:0]    BOUNCE_LOAD = 4'(BOUNCES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [W:0]    W_ONE       = (W+1)'(1);

    state_t        state;
    logic          target;
    logic [W:0]    wcnt;
    logic [3:0]    bcnt;
    logic [SW-1:0] scnt;
    logic [15:0]   lfsr;
    logic [W:0]    phase_w;
    logic          unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .seed  (SEED),
        .q     (lfsr)
    );

    // Width of a phase entered on this edge: 1..2^W cycles.
    assign phase_w     = {1'b0, lfsr[W-1:0]} + W_ONE;
    assign unused_lfsr = ^lfsr[15:W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            target  <= 1'b0;
            btn_out <= 1'b0;
            busy    <= 1'b0;
            wcnt    <= '0;
            bcnt    <= '0;
            scnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    btn_out <= target;
                    busy    <= 1'b0;
                    if (level_in != target) begin
                        target  <= level_in;
                        btn_out <= level_in;
                        busy    <= 1'b1;
                        bcnt    <= BOUNCE_LOAD;
                        if (BOUNCE_LOAD != 4'd0) begin
                            state <= GLITCH;
                            wcnt  <= phase_w;
                        end else begin
                            state <= SETTLE;
                            scnt  <= SETTLE_LOAD;
                        end
                    end
                end
                GLITCH: begin
                    btn_out <= ~target;
                    if (wcnt == W_ONE) begin
                        state <= HOLD;
                        wcnt  <= phase_w;
                    end else begin
                        wcnt <= wcnt - W_ONE;
                    end
                end
                HOLD: begin
                    btn_out <= target;
                    if (wcnt == W_ONE) begin
                        bcnt <= bcnt - 4'd1;
                        if (bcnt == 4'd1) begin
                            state <= SETTLE;
                            scnt  <= SETTLE_LOAD;
                        end else begin
                            state <= GLITCH;
                            wcnt  <= phase_w;
                        end
                    end else begin
                        wcnt <= wcnt - W_ONE;
                    end
                end
                SETTLE: begin
                    btn_out <= target;
                    if (scnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        scnt <= scnt - SW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Directed bench for btn_bounce_gen: default, zero-bounce and zero-seed instances.
module tb_btn_bounce_gen;

    logic clk = 1'b0;
    logic reset;
    logic lvl_a, lvl_z, lvl_s;
    logic btn_a, btn_z, btn_s;
    logic busy_a, busy_z, busy_s;

    int total = 0;
    int bad   = 0;

    logic [15:0] ml;
    logic [15:0] ms;
    logic [15:0] lv [0:255];
    int          st [0:255];
    logic        eb [0:255];
    logic        ey [0:255];
    int          blen;

    always #5 clk = ~clk;

    btn_bounce_gen dut (
        .clk      (clk),
        .reset    (reset),
        .level_in (lvl_a),
        .btn_out  (btn_a),
        .busy     (busy_a)
    );

    btn_bounce_gen #(.BOUNCES(0), .SETTLE_CYC(4)) dut_z (
        .clk      (clk),
        .reset    (reset),
        .level_in (lvl_z),
        .btn_out  (btn_z),
        .busy     (busy_z)
    );

    btn_bounce_gen #(.SEED(16'h0000)) dut_s (
        .clk      (clk),
        .reset    (reset),
        .level_in (lvl_s),
        .btn_out  (btn_s),
        .busy     (busy_s)
    );

    function automatic logic [15:0] nxt(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One edge; the reference LFSRs advance exactly as the spec describes.
    task automatic tick();
        @(posedge clk);
        ml = reset ? 16'hACE1 : nxt(ml);
        ms = reset ? 16'h0001 : nxt(ms);
        #1;
    endtask

    // Expected waveform for the cycles after the detecting edge (k = 0 is that edge).
    task automatic build(input logic [15:0] l0, input logic tgt, input int nb, input int sc);
        int s;
        int g;
        lv[0] = l0;
        for (int i = 1; i < 256; i++) lv[i] = nxt(lv[i-1]);
        for (int i = 0; i < 256; i++) st[i] = 0;
        s = 0;
        for (int b = 0; b < nb; b++) begin
            g = int'(lv[s][2:0]) + 1;
            for (int j = 0; j < g; j++) st[s+j] = 1;
            s += g;
            g = int'(lv[s][2:0]) + 1;
            for (int j = 0; j < g; j++) st[s+j] = 2;
            s += g;
        end
        for (int j = 0; j < sc; j++) st[s+j] = 3;
        s += sc;
        blen = s;
        eb[0] = tgt;
        ey[0] = 1'b1;
        for (int k = 1; k < 256; k++) begin
            eb[k] = (st[k-1] == 1) ? ~tgt : tgt;
            ey[k] = (k < blen);
        end
    endtask

    // sel 0: default instance, sel 2: zero-seed instance. toggle_k < 0 disables the mid-burst change.
    task automatic run_check(input int sel, input logic tgt, input int toggle_k, input logic tog_lvl);
        logic ob, oy, prev;
        int gl;
        build((sel == 2) ? ms : ml, tgt, 4, 16);
        gl = 0;
        prev = tgt;
        for (int k = 0; k <= blen; k++) begin
            if (k == toggle_k) lvl_a = tog_lvl;
            tick();
            ob = (sel == 2) ? btn_s : btn_a;
            oy = (sel == 2) ? busy_s : busy_a;
            chk($sformatf("s%0d_btn_k%0d", sel, k), 16'(ob), 16'(eb[k]));
            chk($sformatf("s%0d_busy_k%0d", sel, k), 16'(oy), 16'(ey[k]));
            if (k > 0 && ob != prev && ob == ~tgt) gl++;
            prev = ob;
        end
        chk($sformatf("s%0d_glitch_count", sel), 16'(gl), 16'd4);
    endtask

    initial begin
        ml = 16'h0000;
        ms = 16'h0000;
        reset = 1'b1;
        lvl_a = 1'b1;
        lvl_z = 1'b0;
        lvl_s = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_btn", 16'(btn_a), 16'd0);
            chk("rst_busy", 16'(busy_a), 16'd0);
            chk("rst_btn_z", 16'(btn_z), 16'd0);
        end
        reset = 1'b0;

        // Rise with a drop to 0 mid-burst, then the back-to-back falling burst.
        run_check(0, 1'b1, 5, 1'b0);
        run_check(0, 1'b0, -1, 1'b0);

        // Reset in the middle of a glitch.
        lvl_a = 1'b1;
        tick();
        chk("mr_detect_btn", 16'(btn_a), 16'd1);
        tick();
        chk("mr_glitch_btn", 16'(btn_a), 16'd0);
        chk("mr_glitch_busy", 16'(busy_a), 16'd1);
        reset = 1'b1;
        tick();
        chk("mr_btn", 16'(btn_a), 16'd0);
        chk("mr_busy", 16'(busy_a), 16'd0);
        chk("mr_lfsr", dut.u_lfsr.q, 16'hACE1);
        tick();
        tick();
        reset = 1'b0;
        run_check(0, 1'b1, 5, 1'b0);
        run_check(0, 1'b0, -1, 1'b0);

        // Zero bounces, four settle cycles.
        lvl_z = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            chk($sformatf("z_btn_k%0d", k), 16'(btn_z), 16'd1);
            chk($sformatf("z_busy_k%0d", k), 16'(busy_z), (k < 4) ? 16'd1 : 16'd0);
        end
        lvl_z = 1'b0;
        tick();
        chk("z_fall_btn", 16'(btn_z), 16'd0);
        chk("z_fall_busy", 16'(busy_z), 16'd1);

        // Zero seed behaves as seed 1.
        lvl_s = 1'b1;
        run_check(2, 1'b1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
